// File: rtl/xge_tx_sched_if.sv
// Source-queue and MAC transmit-side signals of the xge_mac TX packet scheduler.
// The master view belongs to the scheduler; the slave view belongs to the sources and the MAC.
interface xge_tx_sched_if #(
  parameter int N_SRC = 4
);
  logic [N_SRC-1:0]    src_val;
  logic [64*N_SRC-1:0] src_data;
  logic [N_SRC-1:0]    src_sop;
  logic [N_SRC-1:0]    src_eop;
  logic [3*N_SRC-1:0]  src_mod;
  logic [N_SRC-1:0]    src_ren;
  logic                pkt_tx_full;
  logic [63:0]         pkt_tx_data;
  logic                pkt_tx_val;
  logic                pkt_tx_sop;
  logic                pkt_tx_eop;
  logic [2:0]          pkt_tx_mod;

  modport master (
    input  src_val, src_data, src_sop, src_eop, src_mod, pkt_tx_full,
    output src_ren, pkt_tx_data, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod
  );

  modport slave (
    output src_val, src_data, src_sop, src_eop, src_mod, pkt_tx_full,
    input  src_ren, pkt_tx_data, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod
  );
endinterface

// File: rtl/xge_tx_sched.sv
// Packet-granular round-robin scheduler feeding the xge_mac pkt_tx interface from N_SRC
// show-ahead source queues; discards words that arrive without a start-of-packet while idle.
module xge_tx_sched #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
) (
  input  logic            clk_156m25,
  input  logic            reset_156m25_n,
  input  logic            sched_en,
  xge_tx_sched_if.master  tx,
  output logic [ID_W-1:0] grant_id,
  output logic            busy,
  output logic [15:0]     drop_cnt
);

  typedef enum logic {IDLE, XFER} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic            first_q, first_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic [63:0]     tx_data_q, tx_data_d;
  logic            tx_val_q, tx_val_d;
  logic            tx_sop_q, tx_sop_d;
  logic            tx_eop_q, tx_eop_d;
  logic [2:0]      tx_mod_q, tx_mod_d;

  logic [N_SRC-1:0] cand, viol, ren;
  logic             win_hit, drop_hit;
  logic [ID_W-1:0]  win_id, drop_id;
  logic             head_val, head_sop, head_eop;
  logic [63:0]      head_data;
  logic [2:0]       head_mod;

  assign cand = tx.src_val & tx.src_sop;
  assign viol = tx.src_val & ~tx.src_sop;

  // Round-robin scan starting just after the last completed grant.
  always_comb begin
    win_hit = 1'b0;
    win_id  = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      if (!win_hit && cand[(int'(last_grant_q) + k) % N_SRC]) begin
        win_hit = 1'b1;
        win_id  = ID_W'((int'(last_grant_q) + k) % N_SRC);
      end
    end
  end

  always_comb begin
    drop_hit = 1'b0;
    drop_id  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (viol[i]) begin
        drop_hit = 1'b1;
        drop_id  = ID_W'(i);
      end
    end
  end

  assign head_val  = tx.src_val[grant_q];
  assign head_sop  = tx.src_sop[grant_q];
  assign head_eop  = tx.src_eop[grant_q];
  assign head_data = tx.src_data[64*int'(grant_q) +: 64];
  assign head_mod  = tx.src_mod[3*int'(grant_q) +: 3];

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    first_d      = first_q;
    drop_cnt_d   = drop_cnt_q;
    tx_data_d    = '0;
    tx_val_d     = 1'b0;
    tx_sop_d     = 1'b0;
    tx_eop_d     = 1'b0;
    tx_mod_d     = '0;
    ren          = '0;
    case (state_q)
      IDLE: begin
        if (sched_en && win_hit) begin
          grant_d = win_id;
          first_d = 1'b1;
          state_d = XFER;
        end
        // A drop runs independently of the grant and of MAC back-pressure.
        if (drop_hit) begin
          ren[drop_id] = 1'b1;
          if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end
      end
      XFER: begin
        if (head_val && !tx.pkt_tx_full) begin
          ren[grant_q] = 1'b1;
          tx_val_d     = 1'b1;
          tx_data_d    = head_data;
          tx_sop_d     = first_q & head_sop;
          tx_eop_d     = head_eop;
          tx_mod_d     = head_eop ? head_mod : 3'd0;
          first_d      = 1'b0;
          if (head_eop) begin
            last_grant_d = grant_q;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_W'(N_SRC - 1);
      first_q      <= 1'b0;
      drop_cnt_q   <= '0;
      tx_data_q    <= '0;
      tx_val_q     <= 1'b0;
      tx_sop_q     <= 1'b0;
      tx_eop_q     <= 1'b0;
      tx_mod_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      first_q      <= first_d;
      drop_cnt_q   <= drop_cnt_d;
      tx_data_q    <= tx_data_d;
      tx_val_q     <= tx_val_d;
      tx_sop_q     <= tx_sop_d;
      tx_eop_q     <= tx_eop_d;
      tx_mod_q     <= tx_mod_d;
    end
  end

  // Pop strobes are combinational; gate them so nothing is popped while reset is held.
  assign tx.src_ren     = reset_156m25_n ? ren : '0;
  assign tx.pkt_tx_data = tx_data_q;
  assign tx.pkt_tx_val  = tx_val_q;
  assign tx.pkt_tx_sop  = tx_sop_q;
  assign tx.pkt_tx_eop  = tx_eop_q;
  assign tx.pkt_tx_mod  = tx_mod_q;
  assign grant_id       = grant_q;
  assign busy           = (state_q == XFER);
  assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_xge_tx_sched.sv
// Directed bench for xge_tx_sched: queue-based sources, a rule-level reference model checked
// every cycle, and literal expectations for each scenario.
module tb_xge_tx_sched;
  localparam int N = 4;

  typedef struct {
    logic [63:0] d;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sched_en = 1'b1;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] drop_cnt;

  xge_tx_sched_if #(.N_SRC(N)) tx_if();

  xge_tx_sched #(.N_SRC(N), .ID_W(2)) dut (
    .clk_156m25     (clk),
    .reset_156m25_n (rst_n),
    .sched_en       (sched_en),
    .tx             (tx_if),
    .grant_id       (grant_id),
    .busy           (busy),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  word_t       srcq [N][$];
  int          n_checks = 0;
  int          n_err = 0;
  // reference model: owner is -1 when no packet is in flight
  int          m_owner, m_last, m_first, m_grant, m_drop;
  logic        m_val, m_sop, m_eop;
  logic [63:0] m_data;
  logic [2:0]  m_mod;
  logic [63:0] out_log [$];
  int          grant_log [$];
  int          sop_cnt, eop_cnt;
  logic        prev_busy;
  logic        s_val, s_sop, s_eop, s_busy;
  logic [2:0]  s_mod;
  logic [1:0]  s_grant;
  logic [N-1:0] s_ren;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mkd(input int s, input int p, input int w);
    return (64'(s) << 60) | (64'(p) << 8) | 64'(w);
  endfunction

  function automatic int glog(input int i);
    return (i < grant_log.size()) ? grant_log[i] : -1;
  endfunction

  function automatic logic [63:0] olog(input int i);
    return (i < out_log.size()) ? out_log[i] : 64'hBAD0_BAD0_BAD0_BAD0;
  endfunction

  task automatic push(input int s, input logic [63:0] d, input logic sop, input logic eop,
                      input logic [2:0] mod);
    word_t w;
    w.d = d; w.sop = sop; w.eop = eop; w.mod = mod;
    srcq[s].push_back(w);
  endtask

  task automatic push_pkt(input int s, input int p, input int len, input logic [2:0] mod);
    for (int w = 0; w < len; w++)
      push(s, mkd(s, p, w), w == 0, w == len - 1, (w == len - 1) ? mod : 3'd0);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0) begin
        tx_if.src_val[i]            = 1'b1;
        tx_if.src_data[64*i +: 64]  = srcq[i][0].d;
        tx_if.src_sop[i]            = srcq[i][0].sop;
        tx_if.src_eop[i]            = srcq[i][0].eop;
        tx_if.src_mod[3*i +: 3]     = srcq[i][0].mod;
      end else begin
        tx_if.src_val[i]            = 1'b0;
        tx_if.src_data[64*i +: 64]  = '0;
        tx_if.src_sop[i]            = 1'b0;
        tx_if.src_eop[i]            = 1'b0;
        tx_if.src_mod[3*i +: 3]     = '0;
      end
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_first = 0; m_grant = 0; m_drop = 0;
    m_val = 0; m_sop = 0; m_eop = 0; m_data = '0; m_mod = '0;
  endtask

  task automatic clear_logs();
    out_log.delete(); grant_log.delete();
    sop_cnt = 0; eop_cnt = 0; prev_busy = 0;
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) srcq[i].delete();
  endtask

  // One clock: compare at the falling edge, advance the model, pop sources after the rising edge.
  task automatic cycle();
    logic [N-1:0] exp_ren;
    int           w;
    bit           hit;
    bit           dropped;
    word_t        hw;
    drive();
    @(negedge clk);
    s_val = tx_if.pkt_tx_val; s_sop = tx_if.pkt_tx_sop; s_eop = tx_if.pkt_tx_eop;
    s_mod = tx_if.pkt_tx_mod; s_busy = busy; s_grant = grant_id; s_ren = tx_if.src_ren;
    chk("pkt_tx_val", tx_if.pkt_tx_val, m_val);
    chk("pkt_tx_data", tx_if.pkt_tx_data, m_data);
    chk("pkt_tx_sop", tx_if.pkt_tx_sop, m_sop);
    chk("pkt_tx_eop", tx_if.pkt_tx_eop, m_eop);
    chk("pkt_tx_mod", tx_if.pkt_tx_mod, m_mod);
    chk("grant_id", grant_id, m_grant);
    chk("busy", busy, m_owner >= 0);
    chk("drop_cnt", drop_cnt, m_drop);
    exp_ren = '0; hit = 0; dropped = 0; w = 0;
    if (m_owner < 0) begin
      for (int i = 0; i < N; i++)
        if (!dropped && srcq[i].size() > 0 && !srcq[i][0].sop) begin
          exp_ren[i] = 1'b1; dropped = 1;
        end
      if (sched_en)
        for (int k = 1; k <= N; k++)
          if (!hit && srcq[(m_last + k) % N].size() > 0 && srcq[(m_last + k) % N][0].sop) begin
            hit = 1; w = (m_last + k) % N;
          end
    end else if (srcq[m_owner].size() > 0 && !tx_if.pkt_tx_full) begin
      exp_ren[m_owner] = 1'b1;
    end
    chk("src_ren", tx_if.src_ren, exp_ren);
    if (s_val) out_log.push_back(tx_if.pkt_tx_data);
    if (s_val && s_sop) sop_cnt++;
    if (s_val && s_eop) eop_cnt++;
    if (s_busy && !prev_busy) grant_log.push_back(int'(s_grant));
    prev_busy = s_busy;
    m_val = 0; m_sop = 0; m_eop = 0; m_data = '0; m_mod = '0;
    if (m_owner < 0) begin
      if (dropped && m_drop < 65535) m_drop++;
      if (hit) begin m_owner = w; m_grant = w; m_first = 1; end
    end else if (exp_ren[m_owner]) begin
      hw = srcq[m_owner][0];
      m_val = 1; m_data = hw.d; m_sop = hw.sop && (m_first == 1); m_eop = hw.eop;
      m_mod = hw.eop ? hw.mod : 3'd0;
      m_first = 0;
      if (hw.eop) begin m_last = m_owner; m_owner = -1; end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (s_ren[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
  endtask

  task automatic run_idle(input string nm, input int max);
    int  n;
    bit  pending;
    n = 0;
    do begin
      cycle();
      n++;
      pending = s_busy || s_val;
      for (int i = 0; i < N; i++) if (srcq[i].size() > 0) pending = 1;
    end while (pending && n < max);
    chk(nm, pending, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush(); model_reset(); drive();
    #1;
    chk("rst_pkt_tx_val", tx_if.pkt_tx_val, 1'b0);
    chk("rst_pkt_tx_data", tx_if.pkt_tx_data, 64'd0);
    chk("rst_src_ren", tx_if.src_ren, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant_id", grant_id, 2'd0);
    chk("rst_drop_cnt", drop_cnt, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
  endtask

  initial begin
    logic [6:0] vpat, spat, epat;
    logic [2:0] mod_at_eop;
    logic [1:0] g_at1;
    int         ord [6];
    int         pk  [6];
    tx_if.pkt_tx_full = 1'b0;
    ord = '{0, 1, 2, 3, 0, 1};
    pk  = '{0, 0, 0, 0, 1, 1};

    // Single 3-word packet on source 2
    do_reset();
    push_pkt(2, 0, 3, 3'd5);
    vpat = '0; spat = '0; epat = '0; mod_at_eop = '0; g_at1 = '0;
    for (int c = 0; c < 7; c++) begin
      cycle();
      vpat[c] = s_val; spat[c] = s_sop; epat[c] = s_eop;
      if (s_eop) mod_at_eop = s_mod;
      if (c == 1) g_at1 = s_grant;
    end
    chk("t1_grant", g_at1, 2'd2);
    chk("t1_val_pattern", vpat, 7'b0011100);
    chk("t1_sop_pattern", spat, 7'b0000100);
    chk("t1_eop_pattern", epat, 7'b0010000);
    chk("t1_mod", mod_at_eop, 3'd5);
    chk("t1_word2", olog(2), 64'h2000_0000_0000_0002);

    // Four sources with back-to-back 2-word packets
    do_reset();
    for (int s = 0; s < N; s++) push_pkt(s, 0, 2, 3'd3);
    push_pkt(0, 1, 2, 3'd3);
    push_pkt(1, 1, 2, 3'd3);
    run_idle("t2_timeout", 80);
    chk("t2_grants", grant_log.size(), 6);
    for (int p = 0; p < 6; p++) begin
      chk("t2_order", glog(p), ord[p]);
      for (int w = 0; w < 2; w++) chk("t2_data", olog(2*p + w), mkd(ord[p], pk[p], w));
    end
    chk("t2_sop_cnt", sop_cnt, 6);
    chk("t2_eop_cnt", eop_cnt, 6);

    // Back-pressure mid-packet on source 1
    do_reset();
    for (int i = 0; i < 8; i++) push(1, 64'h1000_0000_0000_0000 + 64'(i), i == 0, i == 7, 3'd0);
    repeat (3) cycle();
    tx_if.pkt_tx_full = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("t3_ren_full", s_ren[1], 1'b0);
    end
    tx_if.pkt_tx_full = 1'b0;
    run_idle("t3_timeout", 40);
    chk("t3_words", out_log.size(), 8);
    for (int i = 0; i < 8; i++) chk("t3_data", olog(i), 64'h1000_0000_0000_0000 + 64'(i));

    // Framing violation on source 3 while idle
    do_reset();
    push(3, 64'hDEAD_BEEF_0000_0000, 1'b0, 1'b0, 3'd0);
    push_pkt(3, 0, 2, 3'd2);
    run_idle("t4_timeout", 30);
    chk("t4_drop_cnt", drop_cnt, 16'd1);
    chk("t4_words", out_log.size(), 2);
    chk("t4_first", olog(0), mkd(3, 0, 0));
    chk("t4_grant", glog(0), 3);

    // Scheduler disabled mid-packet
    do_reset();
    push_pkt(0, 0, 4, 3'd1);
    repeat (2) cycle();
    sched_en = 1'b0;
    for (int s = 1; s < N; s++) push_pkt(s, 0, 1, 3'd4);
    repeat (12) cycle();
    chk("t5_grants_off", grant_log.size(), 1);
    chk("t5_words", out_log.size(), 4);
    chk("t5_eop_cnt", eop_cnt, 1);
    chk("t5_busy", busy, 1'b0);
    chk("t5_pending", srcq[1].size() + srcq[2].size() + srcq[3].size(), 3);
    sched_en = 1'b1;
    run_idle("t5_timeout", 40);
    chk("t5_regrant", glog(1), 1);
    chk("t5_grants_on", grant_log.size(), 4);

    // Asynchronous reset mid-packet
    do_reset();
    push_pkt(2, 0, 6, 3'd0);
    repeat (4) cycle();
    chk("t6_val_before", tx_if.pkt_tx_val, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_val_async", tx_if.pkt_tx_val, 1'b0);
    chk("t6_ren_async", tx_if.src_ren, 4'd0);
    chk("t6_busy_async", busy, 1'b0);
    flush(); model_reset();
    push(0, 64'hBAD, 1'b0, 1'b0, 3'd0);
    push_pkt(3, 0, 2, 3'd0);
    push_pkt(1, 0, 2, 3'd0);
    drive();
    #1;
    chk("t6_ren_held", tx_if.src_ren, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
    run_idle("t6_timeout", 40);
    chk("t6_first_grant", glog(0), 1);
    chk("t6_second_grant", glog(1), 3);
    chk("t6_drop_cnt", drop_cnt, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
